game_scheduler: RTL and testbench

GAME_SCHEDULER -- requirements
Module: game_scheduler

---
 rtl/game_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_game_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_scheduler.sv
// Game scheduler: sequences spawn/exec/lock operations on the board engine,
// runs the gravity timer and keeps level and line statistics.
module game_scheduler #(
    parameter int TICK_BASE = 50_000_000,
    parameter int TICK_STEP = 2_500_000,
    parameter int TICK_MIN  = 5_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        cmd_valid,
    input  logic [3:0]  cmd_code,
    output logic        cmd_ready,
    output logic        op_start,
    output logic [3:0]  op_code,
    input  logic        op_done,
    input  logic        op_ok,
    input  logic [2:0]  lines_cleared,
    output logic [3:0]  level,
    output logic [15:0] lines_total,
    output logic        game_over,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_READY,
        S_EXEC,
        S_LOCK,
        S_OVER
    } state_t;

    localparam logic [3:0]  C_NONE  = 4'd0;
    localparam logic [3:0]  C_DOWN  = 4'd3;
    localparam logic [3:0]  C_DROP  = 4'd4;
    localparam logic [3:0]  C_SPAWN = 4'd8;
    localparam logic [3:0]  C_LOCK  = 4'd9;
    localparam logic [31:0] BASE32  = 32'(TICK_BASE);
    localparam logic [31:0] STEP32  = 32'(TICK_STEP);
    localparam logic [31:0] MIN32   = 32'(TICK_MIN);

    state_t      r_state;
    state_t      w_next;
    logic        r_op_start;
    logic [3:0]  r_op_code;
    logic [31:0] r_grav;
    logic [3:0]  r_level;
    logic [3:0]  r_lil;
    logic [15:0] r_lines;

    logic        w_busy;
    logic        w_ready;
    logic        w_done;
    logic        w_accept;
    logic        w_launch;
    logic        w_reload;
    logic        w_clear;
    logic        w_lock_done;
    logic [3:0]  w_code;
    logic [31:0] w_prod;
    logic [31:0] w_sub;
    logic [31:0] w_period;
    logic [31:0] w_reload_val;
    logic [4:0]  w_lil_sum;
    logic [16:0] w_lines_sum;

    assign w_busy   = (r_state == S_SPAWN) || (r_state == S_EXEC) ||
                      (r_state == S_LOCK);
    assign w_ready  = (r_state == S_READY) && (r_grav != 32'd0);
    // op_done in the op_start cycle is too early to belong to this op
    assign w_done   = op_done && w_busy && !r_op_start;
    assign w_accept = cmd_valid && w_ready;

    assign cmd_ready   = w_ready;
    assign op_start    = r_op_start;
    assign op_code     = r_op_code;
    assign level       = r_level;
    assign lines_total = r_lines;
    assign game_over   = (r_state == S_OVER);
    assign busy        = w_busy;

    // Gravity period for the current level, floored then clamped
    always_comb begin
        w_prod       = 32'(r_level) * STEP32;
        w_sub        = (BASE32 > w_prod) ? (BASE32 - w_prod) : 32'd0;
        w_period     = (w_sub > MIN32) ? w_sub : MIN32;
        w_reload_val = w_period - 32'd1;
    end

    // Next-state and operation selection
    always_comb begin
        w_next      = r_state;
        w_code      = r_op_code;
        w_reload    = 1'b0;
        w_clear     = 1'b0;
        w_lock_done = 1'b0;
        unique case (r_state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    w_clear = 1'b1;
                    w_next  = S_SPAWN;
                    w_code  = C_SPAWN;
                end
            end
            S_SPAWN: begin
                if (w_done) begin
                    if (op_ok) begin
                        w_reload = 1'b1;
                        w_next   = S_READY;
                    end else begin
                        w_next = S_OVER;
                    end
                end
            end
            S_READY: begin
                if (r_grav == 32'd0) begin
                    w_next = S_EXEC;
                    w_code = C_DOWN;
                end else if (w_accept &&
                             (cmd_code inside {[4'd1:4'd7]})) begin
                    w_next = S_EXEC;
                    w_code = cmd_code;
                end
            end
            S_EXEC: begin
                if (w_done) begin
                    if (r_op_code == C_DROP) begin
                        w_next = S_LOCK;
                        w_code = C_LOCK;
                    end else if (r_op_code == C_DOWN) begin
                        if (op_ok) begin
                            w_reload = 1'b1;
                            w_next   = S_READY;
                        end else begin
                            w_next = S_LOCK;
                            w_code = C_LOCK;
                        end
                    end else begin
                        w_next = S_READY;
                    end
                end
            end
            S_LOCK: begin
                if (w_done) begin
                    w_lock_done = 1'b1;
                    w_next      = S_SPAWN;
                    w_code      = C_SPAWN;
                end
            end
            default: w_next = S_IDLE;
        endcase
        w_launch = (w_next != r_state) &&
                   ((w_next == S_SPAWN) || (w_next == S_EXEC) ||
                    (w_next == S_LOCK));
    end

    // State register with the launch pulse and held operation code
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_op_start <= 1'b0;
            r_op_code  <= C_NONE;
        end else begin
            r_state    <= w_next;
            r_op_start <= w_launch;
            if (w_launch) begin
                r_op_code <= w_code;
            end
        end
    end

    // Gravity counter: reload on successful spawn/down, else count down
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_grav <= 32'd0;
        end else if (w_reload) begin
            r_grav <= w_reload_val;
        end else if (((r_state == S_READY) || (r_state == S_EXEC)) &&
                     (r_grav != 32'd0)) begin
            r_grav <= r_grav - 32'd1;
        end
    end

    assign w_lil_sum   = {1'b0, r_lil} + {2'b00, lines_cleared};
    assign w_lines_sum = {1'b0, r_lines} + {14'd0, lines_cleared};

    // Line statistics and level progression on each completed lock
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_lines <= 16'd0;
            r_lil   <= 4'd0;
            r_level <= 4'd0;
        end else if (w_clear) begin
            r_lines <= 16'd0;
            r_lil   <= 4'd0;
            r_level <= 4'd0;
        end else if (w_lock_done) begin
            r_lines <= w_lines_sum[16] ? 16'hFFFF : w_lines_sum[15:0];
            if (w_lil_sum >= 5'd10) begin
                r_lil <= 4'(w_lil_sum - 5'd10);
                if (r_level != 4'd15) begin
                    r_level <= r_level + 4'd1;
                end
            end else begin
                r_lil <= w_lil_sum[3:0];
            end
        end
    end

endmodule

// File: tb/tb_game_scheduler.sv
// Directed bench for game_scheduler with a small scripted board engine.
// Short gravity periods so timing can be counted cycle by cycle.
module tb_game_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        cmd_valid;
    logic [3:0]  cmd_code;
    logic        cmd_ready;
    logic        op_start;
    logic [3:0]  op_code;
    logic        op_done;
    logic        op_ok;
    logic [2:0]  lines_cleared;
    logic [3:0]  level;
    logic [15:0] lines_total;
    logic        game_over;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int n_starts = 0;

    game_scheduler #(
        .TICK_BASE(20),
        .TICK_STEP(4),
        .TICK_MIN (5)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .cmd_valid    (cmd_valid),
        .cmd_code     (cmd_code),
        .cmd_ready    (cmd_ready),
        .op_start     (op_start),
        .op_code      (op_code),
        .op_done      (op_done),
        .op_ok        (op_ok),
        .lines_cleared(lines_cleared),
        .level        (level),
        .lines_total  (lines_total),
        .game_over    (game_over),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Count every launch pulse seen by the engine
    always @(posedge clk) begin
        if (op_start === 1'b1) n_starts <= n_starts + 1;
    end

    typedef struct {
        logic [2:0] lc;
        int         total;
        int         lvl;
        int         period;
    } vec_t;

    vec_t tv[17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_start(input int max, output int n);
        n = 0;
        while (op_start !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        if (op_start !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL wait_start: no op_start within %0d cycles", max);
        end
    endtask

    task automatic respond(input int dly, input logic ok,
                           input logic [2:0] lc);
        repeat (dly) tick();
        op_done = 1'b1;
        op_ok = ok;
        lines_cleared = lc;
        tick();
        op_done = 1'b0;
        op_ok = 1'b0;
        lines_cleared = 3'd0;
    endtask

    task automatic send(input logic [3:0] code);
        cmd_valid = 1'b1;
        cmd_code = code;
        tick();
        cmd_valid = 1'b0;
        cmd_code = 4'd0;
    endtask

    initial begin
        int n;
        int s0;
        tv[0]  = '{3'd4, 8,  0, 20};
        tv[1]  = '{3'd3, 11, 1, 16};
        tv[2]  = '{3'd0, 11, 1, 16};
        tv[3]  = '{3'd4, 15, 1, 16};
        tv[4]  = '{3'd4, 19, 1, 16};
        tv[5]  = '{3'd1, 20, 2, 12};
        tv[6]  = '{3'd4, 24, 2, 12};
        tv[7]  = '{3'd4, 28, 2, 12};
        tv[8]  = '{3'd4, 32, 3, 8};
        tv[9]  = '{3'd4, 36, 3, 8};
        tv[10] = '{3'd4, 40, 4, 5};
        tv[11] = '{3'd4, 44, 4, 5};
        tv[12] = '{3'd4, 48, 4, 5};
        tv[13] = '{3'd2, 50, 5, 5};
        tv[14] = '{3'd4, 54, 5, 5};
        tv[15] = '{3'd4, 58, 5, 5};
        tv[16] = '{3'd2, 60, 6, 5};

        reset_n = 1'b0;
        start = 1'b0;
        cmd_valid = 1'b0;
        cmd_code = 4'd0;
        op_done = 1'b0;
        op_ok = 1'b0;
        lines_cleared = 3'd0;
        repeat (3) tick();
        chk("rst_op_start", op_start, 0);
        chk("rst_op_code", op_code, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_lines", lines_total, 0);
        chk("rst_game_over", game_over, 0);
        reset_n = 1'b1;
        tick();

        // start -> single SPAWN op, engine answers after 3 cycles
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("spawn_start", op_start, 1);
        chk("spawn_code", op_code, 8);
        chk("spawn_busy", busy, 1);
        respond(3, 1'b1, 3'd0);
        chk("ready_cmd_ready", cmd_ready, 1);
        chk("ready_busy", busy, 0);
        chk("spawn_once", n_starts, 1);

        // gravity at level 0: 20 cycles after READY entry and after reload
        wait_start(40, n);
        chk("grav1_period", n, 20);
        chk("grav1_code", op_code, 3);
        respond(1, 1'b1, 3'd0);
        wait_start(40, n);
        chk("grav2_period", n, 20);
        respond(1, 1'b1, 3'd0);

        // LEFT failing does not reload gravity
        chk("left_ready", cmd_ready, 1);
        send(4'd1);
        chk("left_start", op_start, 1);
        chk("left_code", op_code, 1);
        respond(2, 1'b0, 3'd0);
        chk("left_back_ready", cmd_ready, 1);
        wait_start(40, n);
        chk("left_no_reload", n, 16);
        chk("left_grav_code", op_code, 3);
        respond(1, 1'b1, 3'd0);

        // dropped commands stay in READY
        send(4'd0);
        send(4'd12);
        chk("drop_none_code", op_start, 0);
        chk("drop_none_rdy", cmd_ready, 1);

        // DROP -> LOCK clearing 4 -> SPAWN
        send(4'd4);
        chk("drop_code", op_code, 4);
        respond(1, 1'b1, 3'd0);
        chk("lock_start", op_start, 1);
        chk("lock_code", op_code, 9);
        respond(1, 1'b1, 3'd4);
        chk("lock_lines", lines_total, 4);
        chk("lock_spawn_code", op_code, 8);
        chk("lock_spawn_start", op_start, 1);
        respond(1, 1'b1, 3'd0);

        // table: repeated locks, level changes and gravity period
        for (int i = 0; i < 17; i++) begin
            send(4'd4);
            respond(1, 1'b1, 3'd0);
            chk($sformatf("tv%0d_lock", i), op_code, 9);
            respond(1, 1'b1, tv[i].lc);
            chk($sformatf("tv%0d_total", i), lines_total, tv[i].total);
            chk($sformatf("tv%0d_level", i), level, tv[i].lvl);
            respond(1, 1'b1, 3'd0);
            wait_start(40, n);
            chk($sformatf("tv%0d_period", i), n, tv[i].period);
            respond(1, 1'b1, 3'd0);
        end

        // gravity wins over a command offered at counter==0 (period 5)
        repeat (4) tick();
        cmd_valid = 1'b1;
        cmd_code = 4'd1;
        chk("coll_cmd_ready", cmd_ready, 0);
        tick();
        chk("coll_start", op_start, 1);
        chk("coll_code", op_code, 3);
        chk("coll_exec_rdy", cmd_ready, 0);
        respond(1, 1'b1, 3'd0);
        chk("coll_retained_rdy", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        cmd_code = 4'd0;
        chk("coll_left_code", op_code, 1);
        chk("coll_left_start", op_start, 1);

        // op_done in the op_start cycle is ignored
        op_done = 1'b1;
        op_ok = 1'b1;
        tick();
        op_done = 1'b0;
        op_ok = 1'b0;
        chk("early_done_busy", busy, 1);
        respond(1, 1'b1, 3'd0);
        chk("late_done_busy", busy, 0);
        wait_start(10, n);
        chk("left_exhausted", n, 1);
        respond(1, 1'b1, 3'd0);

        // start ignored while playing
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ign_op", op_start, 0);
        chk("start_ign_rdy", cmd_ready, 1);

        // failed spawn -> game over
        send(4'd4);
        respond(1, 1'b1, 3'd0);
        respond(1, 1'b1, 3'd0);
        respond(1, 1'b0, 3'd0);
        chk("over_flag", game_over, 1);
        chk("over_rdy", cmd_ready, 0);
        chk("over_busy", busy, 0);
        s0 = n_starts;
        repeat (5) tick();
        chk("over_no_op", n_starts, s0);

        // new game clears stats
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("new_over", game_over, 0);
        chk("new_level", level, 0);
        chk("new_lines", lines_total, 0);
        chk("new_spawn", op_code, 8);
        respond(1, 1'b1, 3'd0);
        wait_start(40, n);
        chk("new_period", n, 20);

        // reset mid-EXEC, then a stale op_done
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        op_done = 1'b1;
        op_ok = 1'b1;
        tick();
        op_done = 1'b0;
        op_ok = 1'b0;
        tick();
        chk("mid_op_start", op_start, 0);
        chk("mid_op_code", op_code, 0);
        chk("mid_rdy", cmd_ready, 0);
        chk("mid_busy", busy, 0);
        chk("mid_level", level, 0);
        chk("mid_lines", lines_total, 0);
        chk("mid_over", game_over, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("post_rst_spawn", op_code, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
